// File: rtl/sync_fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO controller.
// Optional build macro: SYNC_FIFO_FWFT_EN (first-word-fall-through read).
package sync_fifo_pkg;

   localparam int DATA_SIZE_DEF = 8;
   localparam int ADDR_SIZE_DEF = 6;
   localparam int CNT_W         = ADDR_SIZE_DEF + 1;

   typedef logic [CNT_W-1:0] cnt_t;

   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one write port, registered or fall-through read port.
// SYNC_FIFO_FWFT_EN selects the combinational read path.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DW = DATA_SIZE_DEF,
   parameter int AW = ADDR_SIZE_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   localparam int DEPTH = fifo_depth(AW);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   logic unused_rd;

   assign unused_rd = re_i ^ rst;
   assign rdata_o   = mem_q[raddr_i];
`else
   logic [DW-1:0] rdata_q;
   logic [DW-1:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (rst) begin
         rdata_d = '0;
      end else if (re_i) begin
         rdata_d = mem_q[raddr_i];
      end
   end

   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy, thresholds and sticky errors.
// Build with SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_ctrl
   import sync_fifo_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 winc,
   input  logic [DATA_SIZE-1:0] wData,
   input  logic                 rinc,
   output logic [DATA_SIZE-1:0] rData,
   output logic                 rValid,
   output logic                 wFull,
   output logic                 rEmpty,
   input  logic [ADDR_SIZE:0]   af_thresh,
   input  logic [ADDR_SIZE:0]   ae_thresh,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [ADDR_SIZE:0]   count,
   output logic                 overflow,
   output logic                 underflow,
   input  logic                 clr_err
);

   localparam int DEPTH = fifo_depth(ADDR_SIZE);
   localparam logic [ADDR_SIZE:0] FULL_CNT = (ADDR_SIZE+1)'(DEPTH);

   logic [ADDR_SIZE:0] wptr_q, wptr_d;
   logic [ADDR_SIZE:0] rptr_q, rptr_d;
   logic [ADDR_SIZE:0] cnt_q, cnt_d;
   logic               rvalid_q, rvalid_d;
   logic               ovf_q, ovf_d;
   logic               udf_q, udf_d;
   logic               wacc, racc;

   assign wFull  = (cnt_q == FULL_CNT);
   assign rEmpty = (cnt_q == '0);
   assign wacc   = winc & ~wFull & ~rst;
   assign racc   = rinc & ~rEmpty & ~rst;

   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      cnt_d    = cnt_q;
      rvalid_d = racc;
      ovf_d    = (winc & wFull) | (ovf_q & ~clr_err);
      udf_d    = (rinc & rEmpty) | (udf_q & ~clr_err);
      if (wacc) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (racc) begin
         rptr_d = rptr_q + 1'b1;
      end
      if (wacc & ~racc) begin
         cnt_d = cnt_q + 1'b1;
      end else if (racc & ~wacc) begin
         cnt_d = cnt_q - 1'b1;
      end
      if (rst) begin
         wptr_d   = '0;
         rptr_d   = '0;
         cnt_d    = '0;
         rvalid_d = 1'b0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
   end

   sync_fifo_mem #(
      .DW (DATA_SIZE),
      .AW (ADDR_SIZE)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wacc),
      .waddr_i (wptr_q[ADDR_SIZE-1:0]),
      .wdata_i (wData),
      .re_i    (racc),
      .raddr_i (rptr_q[ADDR_SIZE-1:0]),
      .rdata_o (rData)
   );

`ifdef SYNC_FIFO_FWFT_EN
   logic unused_rvalid;

   assign unused_rvalid = rvalid_q;
   assign rValid        = ~rEmpty;
`else
   assign rValid = rvalid_q;
`endif

   // Flags come from the registered count only.
   assign almost_full  = (cnt_q >= af_thresh);
   assign almost_empty = (cnt_q <= ae_thresh);
   assign count        = cnt_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule
